mem_responder: RTL and testbench

Word-addressed data-memory responder that serves load/store requests from the processor datapath's memory port (address, write data, write enable) and returns read data. It sits between the datapath and the on-chip data RAM. It inserts a programmable number of wait states and signals completion with a one-cycle `ready` pulse. Misaligned and out-of-range accesses complete with `err` set, and memory is left untouched.

---
 rtl/mem_responder_if.sv | 15 +
 rtl/mem_responder.sv | 113 +++++++++++
 tb/tb_mem_responder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Datapath-to-data-RAM memory port: request fields from the datapath and the
// registered response returned by mem_responder.
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (output req, we, addr, wdata, input rdata, ready, err, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err, busy);
endinterface

// File: rtl/mem_responder.sv
// Word-addressed data-memory responder: latches one load/store, waits WAIT
// cycles, performs the access and returns a one-cycle ready pulse.
module mem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT < 1) ? 1 : $clog2(WAIT + 1);
  localparam logic [CW-1:0] CNT_LOAD = (WAIT > 0) ? CW'(WAIT - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT_ST, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   mem [DEPTH];

  logic          acc_go;
  logic          acc_we;
  logic          acc_err;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;

  // With WAIT=0 the access happens at the acceptance edge, so it must use the
  // live request fields rather than the latched copies.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    acc_go    = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state == IDLE) begin
      acc_go    = bus.req && (WAIT == 0);
      acc_we    = bus.we;
      acc_addr  = bus.addr;
      acc_wdata = bus.wdata;
    end else if (state == WAIT_ST) begin
      acc_go = (cnt == '0);
    end
    // The full word index is range-checked so high address bits never alias.
    acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH));
    acc_idx = acc_addr[AW+1:2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req) state_nxt = (WAIT == 0) ? RESP : WAIT_ST;
      WAIT_ST: if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state != IDLE);
    bus.ready = (state == RESP);
    bus.rdata = rdata_q;
    bus.err   = err_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.req) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        cnt     <= CNT_LOAD;
      end else if (state == WAIT_ST && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end

      if (acc_go) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_we) ? '0 : mem[acc_idx];
      end else if (state == RESP) begin
        err_q <= 1'b0;
      end
    end
  end

  // NOTE: the RAM array is deliberately not reset; clearing it would prevent
  // RAM inference and its contents are undefined until written anyway.
  always_ff @(posedge clk) begin
    if (reset && acc_go && acc_we && !acc_err) mem[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with WAIT=2, one with WAIT=0.
module tb_mem_responder;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  mem_responder_if b2 ();
  mem_responder_if b0 ();

  mem_responder #(.DEPTH(64), .WAIT(2)) u_w2 (.clk(clk), .reset(reset), .bus(b2));
  mem_responder #(.DEPTH(64), .WAIT(0)) u_w0 (.clk(clk), .reset(reset), .bus(b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100us;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One WAIT=2 transaction, checked cycle by cycle from acceptance to IDLE.
  task automatic txn2(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic e_err, input logic [31:0] e_rdata);
    @(negedge clk);
    b2.req = 1'b1; b2.we = w; b2.addr = a; b2.wdata = d;
    @(negedge clk);
    b2.req = 1'b0; b2.we = ~w; b2.addr = 32'hFFFF_FFFC; b2.wdata = 32'h5555_5555;
    check({tag, "/busy_c1"},  32'(b2.busy),  32'd1);
    check({tag, "/ready_c1"}, 32'(b2.ready), 32'd0);
    @(negedge clk);
    check({tag, "/busy_c2"},  32'(b2.busy),  32'd1);
    check({tag, "/ready_c2"}, 32'(b2.ready), 32'd0);
    @(negedge clk);
    check({tag, "/busy_c3"},  32'(b2.busy),  32'd1);
    check({tag, "/ready_c3"}, 32'(b2.ready), 32'd1);
    check({tag, "/err"},      32'(b2.err),   32'(e_err));
    check({tag, "/rdata"},    b2.rdata,      e_rdata);
    @(negedge clk);
    check({tag, "/busy_end"},  32'(b2.busy),  32'd0);
    check({tag, "/ready_end"}, 32'(b2.ready), 32'd0);
    check({tag, "/err_end"},   32'(b2.err),   32'd0);
    check({tag, "/rdata_hold"}, b2.rdata,     e_rdata);
  endtask

  initial begin
    logic [31:0] last_store;
    logic        cur_we;
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    b2.req = 1'b0; b2.we = 1'b0; b2.addr = '0; b2.wdata = '0;
    b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst/ready", 32'(b2.ready), 32'd0);
    check("rst/err",   32'(b2.err),   32'd0);
    check("rst/rdata", b2.rdata,      32'd0);
    check("rst/busy",  32'(b2.busy),  32'd0);
    check("rst0/ready", 32'(b0.ready), 32'd0);
    check("rst0/busy",  32'(b0.busy),  32'd0);
    reset = 1'b1;

    // Basic store then load
    txn2("st10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0);
    txn2("ld10", 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF);

    // Setup words 0, 4, 8, 0x20
    txn2("st04", 1'b1, 32'h0000_0004, 32'h1111_1111, 1'b0, 32'h0);
    txn2("st08", 1'b1, 32'h0000_0008, 32'h2222_2222, 1'b0, 32'h0);
    txn2("st00", 1'b1, 32'h0000_0000, 32'hA5A5_5A5A, 1'b0, 32'h0);
    txn2("st20", 1'b1, 32'h0000_0020, 32'h1357_9BDF, 1'b0, 32'h0);

    // Misaligned accesses: rdata forced to 0 even after a non-zero load
    txn2("ld10b",  1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF);
    txn2("ld_mis", 1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0);
    txn2("st_mis", 1'b1, 32'h0000_0009, 32'h0000_1234, 1'b1, 32'h0);
    txn2("ld08",   1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h2222_2222);
    txn2("ld04",   1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h1111_1111);

    // Out of range: index 64 and a high address bit must not alias word 0
    txn2("st_oor64", 1'b1, 32'h0000_0100, 32'hBAD0_0001, 1'b1, 32'h0);
    txn2("st_oorhi", 1'b1, 32'h8000_0000, 32'hBAD0_0002, 1'b1, 32'h0);
    txn2("ld00",     1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_5A5A);

    // req pulses during WAIT_ST and RESP are ignored
    @(negedge clk);
    b2.req = 1'b1; b2.we = 1'b0; b2.addr = 32'h0000_0010; b2.wdata = 32'h0;
    @(negedge clk);
    b2.we = 1'b1; b2.addr = 32'h0000_0004; b2.wdata = 32'hFFFF_0000;
    check("ign/busy_c1",  32'(b2.busy),  32'd1);
    @(negedge clk);
    b2.req = 1'b0;
    check("ign/ready_c2", 32'(b2.ready), 32'd0);
    @(negedge clk);
    check("ign/ready_c3", 32'(b2.ready), 32'd1);
    check("ign/rdata",    b2.rdata,      32'hDEAD_BEEF);
    check("ign/err",      32'(b2.err),   32'd0);
    b2.req = 1'b1;
    @(negedge clk);
    b2.req = 1'b0;
    check("ign/ready_c4", 32'(b2.ready), 32'd0);
    check("ign/busy_c4",  32'(b2.busy),  32'd0);
    @(negedge clk);
    check("ign/ready_c5", 32'(b2.ready), 32'd0);
    check("ign/busy_c5",  32'(b2.busy),  32'd0);
    txn2("ld04_after_ign", 1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'h1111_1111);

    // WAIT=0, req held high, alternating store/load to word 4
    @(negedge clk);
    cur_we = 1'b1;
    last_store = 32'h0;
    b0.req = 1'b1; b0.we = 1'b1; b0.addr = 32'h0000_0004; b0.wdata = 32'h0000_00A0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("w0/ready_%0d", i), 32'(b0.ready), 32'd1);
      check($sformatf("w0/busy_%0d", i),  32'(b0.busy),  32'd1);
      check($sformatf("w0/err_%0d", i),   32'(b0.err),   32'd0);
      check($sformatf("w0/rdata_%0d", i), b0.rdata, cur_we ? 32'h0 : last_store);
      if (cur_we) last_store = b0.wdata;
      cur_we = ~cur_we;
      b0.we = cur_we;
      b0.wdata = 32'h0000_00A0 + 32'(i + 1);
      @(negedge clk);
      check($sformatf("w0/gap_%0d", i),   32'(b0.ready), 32'd0);
      check($sformatf("w0/idle_%0d", i),  32'(b0.busy),  32'd0);
    end
    b0.req = 1'b0;

    // Reset during WAIT_ST of a store to 0x20
    txn2("ld20", 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h1357_9BDF);
    @(negedge clk);
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h0000_0020; b2.wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    b2.req = 1'b0;
    check("abort/busy_pre", 32'(b2.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort/busy",  32'(b2.busy),  32'd0);
    check("abort/ready", 32'(b2.ready), 32'd0);
    check("abort/err",   32'(b2.err),   32'd0);
    check("abort/rdata", b2.rdata,      32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort/no_ready_%0d", i), 32'(b2.ready), 32'd0);
    end
    txn2("ld20_after_abort", 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h1357_9BDF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
